// File: rtl/bus_dma_ctrl.sv
// bus_dma_ctrl
// Single-channel word-copy DMA controller for the shared system bus.
// The CPU programs SRC, DST and LEN through the slave port and then writes a start.
// The controller copies LEN words from SRC to DST through the master port.
// Each word is one read followed by one write.
// The bus is released for one cycle between words so that other masters can win arbitration.
// When the last word has been written, done is set, and irq follows if it is enabled.
//
// Ports
//   clk, reset           system clock, synchronous active-low reset
//   s_cs_, s_as_, s_rw   slave select/strobe (active-low) and direction (1 = read)
//   s_addr               register select: 0 CTRL, 1 SRC, 2 DST, 3 LEN
//   s_wr_data            slave write data
//   s_rd_data, s_rdy_    slave read data and one-cycle ready pulse (active-low)
//   m_req_, m_grnt_      arbiter request/grant (active-low)
//   m_addr, m_as_, m_rw  master word address, strobe (active-low), direction
//   m_wr_data            master write data
//   m_rd_data, m_rdy_    master read data and ready (active-low)
//   irq                  level interrupt, done & irq_en, registered

module bus_dma_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_cs_,
    input  logic        s_as_,
    input  logic        s_rw,
    input  logic [1:0]  s_addr,
    input  logic [31:0] s_wr_data,
    output logic [31:0] s_rd_data,
    output logic        s_rdy_,
    output logic        m_req_,
    input  logic        m_grnt_,
    output logic [29:0] m_addr,
    output logic        m_as_,
    output logic        m_rw,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rd_data,
    input  logic        m_rdy_,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        NEXT
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] src_q, src_d;
    logic [29:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic        irqEn_q, irqEn_d;
    logic        done_q, done_d;
    logic        irq_q, irq_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] sRdData_q, sRdData_d;
    logic        sRdyN_q, sRdyN_d;

    logic        busy;
    logic        slvAccept;
    logic        unusedWrBits;

    // No register is wider than 30 bits, so the top two bits of write data are ignored.
    assign unusedWrBits = &{1'b0, s_wr_data[31:30]};

    // Next-state logic for the register file, the slave handshake and the copy FSM.
    // Slave accesses are decoded first.
    // The FSM comes afterwards, so that completion of the last word has priority when it sets done.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        irqEn_d   = irqEn_q;
        done_d    = done_q;
        buf_d     = buf_q;
        sRdData_d = '0;

        busy      = (state_q != IDLE);

        // A strobe is not accepted while its own ready pulse is being returned.
        // This keeps s_rdy_ low for exactly one cycle, even if the strobe is held.
        slvAccept = !s_cs_ && !s_as_ && sRdyN_q;
        sRdyN_d   = !slvAccept;

        if (slvAccept && s_rw) begin
            case (s_addr)
                2'd0:    sRdData_d = {29'd0, done_q, irqEn_q, busy};
                2'd1:    sRdData_d = {2'b00, src_q};
                2'd2:    sRdData_d = {2'b00, dst_q};
                default: sRdData_d = {16'd0, len_q};
            endcase
        end

        // While a copy is in progress, only irq_en may change.
        // A start with a zero length completes at once, without touching the bus.
        if (slvAccept && !s_rw) begin
            case (s_addr)
                2'd0: begin
                    done_d  = 1'b0;
                    irqEn_d = s_wr_data[1];
                    if (s_wr_data[0] && !busy) begin
                        if (len_q == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
                2'd1: if (!busy) src_d = s_wr_data[29:0];
                2'd2: if (!busy) dst_d = s_wr_data[29:0];
                default: if (!busy) len_d = s_wr_data[15:0];
            endcase
        end

        case (state_q)
            REQ: begin
                if (!m_grnt_) state_d = READ;
            end
            READ: begin
                if (!m_rdy_) begin
                    buf_d   = m_rd_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!m_rdy_) state_d = NEXT;
            end
            NEXT: begin
                src_d = src_q + 30'd1;
                dst_d = dst_q + 30'd1;
                if (len_q != 16'd0) len_d = len_q - 16'd1;
                if (len_q <= 16'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            default: ;
        endcase

        irq_d = done_q & irqEn_q;
    end

    // The master bus outputs are decoded from the registered state alone.
    // They therefore stay stable for the whole of each access.
    always_comb begin
        m_req_    = 1'b1;
        m_as_     = 1'b1;
        m_rw      = 1'b1;
        m_addr    = '0;
        m_wr_data = '0;
        case (state_q)
            REQ: begin
                m_req_ = 1'b0;
            end
            READ: begin
                m_req_ = 1'b0;
                m_as_  = 1'b0;
                m_addr = src_q;
            end
            WRITE: begin
                m_req_    = 1'b0;
                m_as_     = 1'b0;
                m_rw      = 1'b0;
                m_addr    = dst_q;
                m_wr_data = buf_q;
            end
            default: ;
        endcase
    end

    // State register.
    // Reset abandons any partial word and returns every register to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            irqEn_q   <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            buf_q     <= '0;
            sRdData_q <= '0;
            sRdyN_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            irqEn_q   <= irqEn_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            buf_q     <= buf_d;
            sRdData_q <= sRdData_d;
            sRdyN_q   <= sRdyN_d;
        end
    end

    assign s_rd_data = sRdData_q;
    assign s_rdy_    = sRdyN_q;
    assign irq       = irq_q;

endmodule

// File: doc/bus_dma_ctrl.md
# bus_dma_ctrl

Single-channel word-copy DMA controller on the shared system bus. It is configured through a bus slave port (one chip-select from the address decoder). It moves data through a bus master port (one req_/grnt_ pair on the arbiter), reading a word from SRC and writing it to DST, LEN times. At completion it raises a level interrupt to the CPU.

## Interface
- No parameters. Address width 30 (word address), data width 32, LEN width 16.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- s_cs_  in  1  slave chip select, active-low
- s_as_  in  1  slave address strobe, active-low
- s_rw  in  1  slave access direction: 1 = read, 0 = write
- s_addr  in  2  register select: 0 CTRL, 1 SRC, 2 DST, 3 LEN
- s_wr_data  in  32  register write data
- s_rd_data  out  32  register read data; 0 when s_rdy_ is high
- s_rdy_  out  1  slave ready, active-low
- m_req_  out  1  bus request, active-low
- m_grnt_  in  1  bus grant, active-low
- m_addr  out  30  master word address; 0 when m_as_ is high
- m_as_  out  1  master address strobe, active-low
- m_rw  out  1  master direction: 1 = read, 0 = write
- m_wr_data  out  32  master write data; 0 unless writing
- m_rd_data  in  32  master read data
- m_rdy_  in  1  master ready, active-low
- irq  out  1  interrupt, level, active-high

## Operation
- Registers:
  - CTRL: write bit0 = start, bit1 = irq_en. Any CTRL write clears done.
  - CTRL read: bit0 = busy, bit1 = irq_en, bit2 = done.
  - SRC and DST are 30 bits; LEN is 16 bits, zero-extended on read.
- Slave protocol: a cycle with s_cs_ = 0 and s_as_ = 0 is registered. On the next cycle s_rdy_ = 0 for exactly one cycle, with read data valid in that cycle. Writes take effect at the same edge that s_rdy_ is registered.
- While busy, writes to SRC, DST, LEN and start are ignored. An irq_en write is still accepted.
- A start with LEN = 0 sets done immediately. It does not request the bus and busy stays 0.
- FSM states: IDLE, REQ, READ, WRITE, NEXT.
  - IDLE -> REQ on an accepted start with LEN != 0; busy = 1.
  - REQ: m_req_ = 0. Go to READ on the first cycle m_grnt_ = 0 is sampled.
  - READ: m_req_ = 0, m_as_ = 0, m_rw = 1, m_addr = SRC. On m_rdy_ = 0, latch m_rd_data into the buffer and go to WRITE.
  - WRITE: m_req_ = 0, m_as_ = 0, m_rw = 0, m_addr = DST, m_wr_data = buffer. On m_rdy_ = 0 go to NEXT.
  - NEXT: m_req_ = 1, m_as_ = 1. SRC += 1, DST += 1, LEN -= 1. If the old LEN = 1, go to IDLE with busy = 0 and done = 1. Otherwise go to REQ.
- The bus is released for one cycle between words, so other masters can win arbitration.
- Address increments wrap modulo 2^30 (0x3FFFFFFF + 1 = 0). LEN never underflows.
- The master holds all outputs stable from the start of READ/WRITE until it samples m_rdy_ = 0. There is no timeout.
- If m_grnt_ is lost mid-transfer, the access is not aborted; the arbiter never revokes a grant while req_ is held.
- irq = done & irq_en, as a registered output.

## Timing
- Reset values: m_req_ = 1, m_as_ = 1, m_rw = 1, m_addr = 0, m_wr_data = 0, s_rdy_ = 1, s_rd_data = 0, irq = 0. All registers are 0 and the FSM is in IDLE.
- Reset asserted mid-transfer: all of the above apply at the next edge. A partial word is abandoned.
- Start written at edge T: busy = 1 and state = REQ after T, so m_req_ = 0 in cycle T+1.
- Per word, with m_grnt_ and m_rdy_ already low when sampled: 4 cycles (REQ, READ, WRITE, NEXT). Each extra wait cycle on grant or ready adds 1 cycle.
- done and busy = 0 become visible the cycle after NEXT for the last word. irq follows one cycle later.
- A simultaneous slave access during a transfer is served normally, with 1-cycle s_rdy_ latency.

## Test plan
- Reset, then read CTRL, SRC, DST, LEN -> all read 0, s_rdy_ = 0 exactly one cycle after the strobe, irq = 0.
- SRC = 0x100, DST = 0x200, LEN = 3, CTRL = 0x3, with grant and ready immediate -> reads 0x100 to 0x102 and writes 0x200 to 0x202 with matching data; 12 cycles from the first m_req_ = 0 to done; irq = 1; a CTRL write of 0x2 clears irq.
- Grant withheld 5 cycles and m_rdy_ delayed 3 cycles on each access -> m_addr, m_as_ and m_wr_data stay stable throughout; the copy is still correct; m_req_ = 1 for exactly one cycle between words.
- SRC = 0x3FFFFFFF, LEN = 2 -> the second read address is 0x0. Also: LEN = 0 start -> done = 1 with no m_req_ activity.
- Writes to SRC = 0x55 and to start while busy -> SRC is unchanged and the transfer completes unaffected. A CTRL read mid-transfer returns busy = 1.
- Reset asserted low during WRITE -> the next cycle has m_as_ = 1, m_req_ = 1, all registers 0; a new start afterwards works normally.
